// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the UART RX and TX FIFOs. The controller, its
// interface and the register-file RAM all take their default address width
// from here, so the pointer logic and the storage array always agree on the
// depth.
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Default RAM address width for both UART FIFOs; depth = 2**FIFO_ADDR_WIDTH.
  localparam int FIFO_ADDR_WIDTH = 2;

  // Default word width stored in the UART FIFOs.
  localparam int FIFO_DATA_WIDTH = 8;

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_if
// Request/status bundle between the UART datapath and a FIFO controller.
//   wr, rd, clr_err        : push, pop and error-clear requests (datapath side)
//   wr_en, w_addr, r_addr  : RAM write enable and addresses (controller side)
//   full, empty            : occupancy extremes
//   almost_full/empty      : level thresholds
//   count                  : occupancy, 0 .. 2**ADDR_WIDTH
//   overflow, underflow    : sticky rejected-request flags
// The master modport is the requester; the slave modport is the controller.
// -----------------------------------------------------------------------------
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, clr_err,
    input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface : fifo_ctrl_if

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Complete UART FIFO: fifo_ctrl plus the register-file RAM it addresses, both
// sized from one ADDR_WIDTH. Write is synchronous, read is asynchronous, so
// r_data shows the oldest word whenever the FIFO is not empty.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   ctrl       : fifo_ctrl_if.slave (requests in, status out)
//   w_data     : word written on an accepted push
//   r_data     : word at the current read address
// -----------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_ctrl_if.slave            ctrl,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uCtrl (
    .clk   (clk),
    .reset (reset),
    .bus   (ctrl)
  );

  // Storage has no reset; the controller's pointers define which words are
  // valid.
  always_ff @(posedge clk) begin
    if (ctrl.wr_en) begin
      mem[ctrl.w_addr] <= w_data;
    end
  end

  assign r_data = mem[ctrl.r_addr];

endmodule : fifo

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer and status controller for a 1-write / 1-async-read register-file
// FIFO. Turns push/pop requests into RAM write enable and addresses, and keeps
// occupancy, level and sticky error flags.
// Ports:
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high; clears pointers, count and flags
//   bus    : fifo_ctrl_if.slave (requests in, RAM control and status out)
// Parameters:
//   ADDR_WIDTH : RAM address width, depth = 2**ADDR_WIDTH
//   AF_LEVEL   : almost_full when count >= AF_LEVEL
//   AE_LEVEL   : almost_empty when count <= AE_LEVEL
// -----------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits match.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          pushOk;
  logic          popOk;

  // Next-state logic. A push is still accepted while full if a pop happens in
  // the same cycle: the consumer reads the old word combinationally before the
  // edge and the new word lands in that slot on the edge. A pop is never
  // accepted while empty, even alongside a push, because the RAM has no
  // write-through path. Flags are derived from the next-state pointers and
  // count so they are valid the cycle after the operation.
  always_comb begin
    pushOk  = bus.wr & (~full_q | bus.rd);
    popOk   = bus.rd & ~empty_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (pushOk) begin
      wp_d = wp_q + ONE;
    end
    if (popOk) begin
      rp_d = rp_q + ONE;
    end

    case ({pushOk, popOk})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    // Clear first so an error in the same cycle wins.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.wr & ~pushOk) begin
      ovf_d = 1'b1;
    end
    if (bus.rd & ~popOk) begin
      udf_d = 1'b1;
    end

    empty_d = (wp_d == rp_d);
    full_d  = (wp_d[ADDR_WIDTH] != rp_d[ADDR_WIDTH]) &&
              (wp_d[ADDR_WIDTH-1:0] == rp_d[ADDR_WIDTH-1:0]);
    af_d    = (count_d >= AF_THRESH);
    ae_d    = (count_d <= AE_THRESH);
  end

  // State register. Requests during reset are discarded along with the
  // contents, so no error flag can be raised on a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // The write enable is masked by reset so a push in the reset cycle cannot
  // corrupt the RAM.
  assign bus.wr_en        = pushOk & ~reset;
  assign bus.w_addr       = wp_q[ADDR_WIDTH-1:0];
  assign bus.r_addr       = rp_q[ADDR_WIDTH-1:0];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed plus random checks of fifo_ctrl against a queue-based model of FIFO
// behaviour. A full fifo instance (controller + RAM) runs on the same requests
// so the returned data order can be compared with the model queue.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wData;
  logic [DW-1:0] rData;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  fifo_ctrl_if #(.ADDR_WIDTH(AW)) fbus ();

  fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fifo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .ctrl   (fbus.slave),
    .w_data (wData),
    .r_data (rData)
  );

  assign fbus.wr      = bus.wr;
  assign fbus.rd      = bus.rd;
  assign fbus.clr_err = bus.clr_err;

  always #5 clk = ~clk;

  // Reference model: contents as a queue, totals of accepted operations, and
  // the sticky error flags.
  logic [DW-1:0] modelQ[$];
  int            pushCnt = 0;
  int            popCnt  = 0;
  bit            expOvf  = 1'b0;
  bit            expUdf  = 1'b0;
  int            checks  = 0;
  int            errors  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every registered output of both controllers with the model.
  task automatic checkState();
    int         n;
    logic [2:0] eCount;
    logic [1:0] eW;
    logic [1:0] eR;
    logic [5:0] eFlags;
    n      = modelQ.size();
    eCount = 3'(n);
    eW     = 2'(pushCnt % DEPTH);
    eR     = 2'(popCnt % DEPTH);
    eFlags = {n == DEPTH, n == 0, n >= 3, n <= 1, expOvf, expUdf};
    checkOutput("count", bus.count, eCount);
    checkOutput("w_addr", bus.w_addr, eW);
    checkOutput("r_addr", bus.r_addr, eR);
    checkOutput("flags", {bus.full, bus.empty, bus.almost_full,
                          bus.almost_empty, bus.overflow, bus.underflow}, eFlags);
    checkOutput("fifo_status", {fbus.count, fbus.w_addr, fbus.r_addr, fbus.full,
                                fbus.empty, fbus.almost_full, fbus.almost_empty,
                                fbus.overflow, fbus.underflow},
                               {eCount, eW, eR, eFlags});
  endtask

  // One cycle: drive at the falling edge, check combinational outputs before
  // the rising edge, advance the model, then check registered outputs.
  task automatic applyStimulus(input bit w, input bit r, input bit c,
                               input logic [DW-1:0] d);
    bit pushOk;
    bit popOk;
    @(negedge clk);
    bus.wr      = w;
    bus.rd      = r;
    bus.clr_err = c;
    wData       = d;
    #1;
    pushOk = w && (modelQ.size() < DEPTH || r);
    popOk  = r && (modelQ.size() > 0);
    checkOutput("wr_en", bus.wr_en, pushOk);
    checkOutput("fifo_wr_en", fbus.wr_en, pushOk);
    if (popOk) begin
      checkOutput("r_data", rData, modelQ[0]);
    end
    @(posedge clk);
    if (popOk) begin
      void'(modelQ.pop_front());
      popCnt++;
    end
    if (pushOk) begin
      modelQ.push_back(d);
      pushCnt++;
    end
    if (c) begin
      expOvf = 1'b0;
      expUdf = 1'b0;
    end
    if (w && !pushOk) expOvf = 1'b1;
    if (r && !popOk)  expUdf = 1'b1;
    #1;
    checkState();
  endtask

  // Synchronous reset pulse with an optional push request in the same cycle.
  task automatic applyReset(input bit w);
    @(negedge clk);
    reset       = 1'b1;
    bus.wr      = w;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    #1;
    checkOutput("wr_en_in_reset", bus.wr_en, 1'b0);
    @(posedge clk);
    modelQ.delete();
    pushCnt = 0;
    popCnt  = 0;
    expOvf  = 1'b0;
    expUdf  = 1'b0;
    #1;
    checkState();
    @(negedge clk);
    reset  = 1'b0;
    bus.wr = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    wData       = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkState();
    checkOutput("wr_en_reset", bus.wr_en, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    // Fill to full, then one rejected push.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);

    // Drain in order, then one rejected pop, then clear errors.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous push and pop while full, then drain.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Simultaneous push and pop while empty, then tidy up.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h66);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);

    // Wrap-around with two entries in flight.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hC1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'hC2 + 8'(i));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Reset while holding three entries with a push pending.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hD0 + 8'(i));
    applyReset(1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_ctrl
